// File: rtl/display_timing_detector.sv
// Receive-side video timing detector: measures line/frame geometry of an incoming
// hsync/vsync/de stream and recovers x/y coordinates aligned with the 2-cycle delayed stream.
module display_timing_detector #(
    parameter bit H_POL = 1'b0,
    parameter bit V_POL = 1'b0,
    parameter int CW    = 16
) (
    input  logic          i_pixclk,
    input  logic          i_rst_n,
    input  logic          i_hs,
    input  logic          i_vs,
    input  logic          i_de,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_de,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_frame,
    output logic [CW-1:0] o_h_total,
    output logic [CW-1:0] o_h_res,
    output logic [CW-1:0] o_v_total,
    output logic [CW-1:0] o_v_res,
    output logic          o_locked
);

    logic          hs_r, vs_r, de_r, s1_vld;
    logic          hs_act_d, vs_act_d;
    logic [CW-1:0] hcnt, decnt, lcnt, acnt, ycnt;
    logic          primed, seen_h, mm, lost, y_done;

    logic          hs_act, vs_act, h_edge, v_edge, sat, meas_hold, line_act, h_mm, frame_ok;
    logic          de_rise, de_fall;
    logic [CW-1:0] h_len, lcnt_n, acnt_n, x_nxt, y_nxt;

    always_comb begin
        hs_act    = (hs_r == H_POL);
        vs_act    = (vs_r == V_POL);
        // s1_vld masks the bogus edge the reset value of the stage-1 flops would create
        h_edge    = s1_vld && hs_act && !hs_act_d;
        v_edge    = s1_vld && vs_act && !vs_act_d;
        sat       = &hcnt;
        meas_hold = lost || sat;
        h_len     = sat ? hcnt : hcnt + CW'(1);
        line_act  = |decnt;
        h_mm      = h_edge && (meas_hold || (h_len != o_h_total) ||
                               (line_act && (decnt != o_h_res)));
        lcnt_n    = lcnt + CW'(h_edge);
        acnt_n    = acnt + CW'(h_edge && line_act);
        frame_ok  = primed && !mm && !h_mm && !lost &&
                    (lcnt_n == o_v_total) && (acnt_n == o_v_res);
        de_rise   = de_r && !o_de;
        de_fall   = !de_r && o_de;

        x_nxt = o_x;
        if (de_rise) begin
            x_nxt = '0;
        end else if (de_r) begin
            x_nxt = o_x + CW'(1);
        end

        y_nxt = ycnt;
        if (v_edge) begin
            y_nxt = '0;
        end else if (de_fall && !y_done) begin
            y_nxt = ycnt + CW'(1);
        end
    end

    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hs_r      <= 1'b0;
            vs_r      <= 1'b0;
            de_r      <= 1'b0;
            s1_vld    <= 1'b0;
            hs_act_d  <= 1'b0;
            vs_act_d  <= 1'b0;
            hcnt      <= '0;
            decnt     <= '0;
            lcnt      <= '0;
            acnt      <= '0;
            ycnt      <= '0;
            primed    <= 1'b0;
            seen_h    <= 1'b0;
            mm        <= 1'b0;
            lost      <= 1'b0;
            y_done    <= 1'b0;
            o_hs      <= 1'b0;
            o_vs      <= 1'b0;
            o_de      <= 1'b0;
            o_x       <= '0;
            o_y       <= '0;
            o_frame   <= 1'b0;
            o_h_total <= '0;
            o_h_res   <= '0;
            o_v_total <= '0;
            o_v_res   <= '0;
            o_locked  <= 1'b0;
        end else begin
            hs_r     <= i_hs;
            vs_r     <= i_vs;
            de_r     <= i_de;
            s1_vld   <= 1'b1;
            hs_act_d <= hs_act;
            vs_act_d <= vs_act;

            if (h_edge) begin
                hcnt <= '0;
            end else if (!sat) begin
                hcnt <= hcnt + CW'(1);
            end

            if (h_edge) begin
                decnt <= CW'(de_r);
            end else if (!(&decnt)) begin
                decnt <= decnt + CW'(de_r);
            end

            if (sat) begin
                lost <= 1'b1;
            end
            if (h_edge) begin
                lost   <= 1'b0;
                seen_h <= 1'b1;
                lcnt   <= lcnt_n;
                acnt   <= acnt_n;
                if (!meas_hold) begin
                    o_h_total <= h_len;
                    if (line_act) begin
                        o_h_res <= decnt;
                    end
                end
            end

            // Simultaneous edges: the line above is already folded into lcnt_n/acnt_n
            if (v_edge) begin
                lcnt <= '0;
                acnt <= '0;
                mm   <= 1'b0;
                if (!meas_hold) begin
                    o_v_total <= lcnt_n;
                    o_v_res   <= acnt_n;
                end
                if (seen_h || h_edge) begin
                    primed <= 1'b1;
                end
            end else if (h_mm) begin
                mm <= 1'b1;
            end

            if (sat) begin
                o_locked <= 1'b0;
            end else if (v_edge) begin
                o_locked <= frame_ok;
            end else if (h_mm) begin
                o_locked <= 1'b0;
            end

            if (h_edge) begin
                y_done <= 1'b0;
            end else if (de_fall) begin
                y_done <= 1'b1;
            end
            ycnt <= y_nxt;

            o_hs    <= hs_r;
            o_vs    <= vs_r;
            o_de    <= de_r;
            o_x     <= x_nxt;
            o_y     <= y_nxt;
            o_frame <= de_r && (x_nxt == '0) && (y_nxt == '0);
        end
    end

endmodule

// File: tb/tb_display_timing_detector.sv
// Bench for display_timing_detector: two instances (active-low and active-high sync)
// fed by small synthetic video timings, checked against a 2-cycle pipeline model.
module tb_display_timing_detector;

    localparam int CWA = 12;
    localparam int CWB = 16;

    typedef struct {
        int hs, hbp, hact, hfp;
        int vs, vbp, vact, vfp;
        bit pol;
    } geo_t;

    typedef struct {
        int frame;
        int inst;
        bit chk_meas;
        bit locked;
        int ht, hr, vt, vr;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n[2];
    logic hs_i[2], vs_i[2], de_i[2];

    logic           a_hs, a_vs, a_de, a_frame, a_locked;
    logic [CWA-1:0] a_x, a_y, a_ht, a_hr, a_vt, a_vr;
    logic           b_hs, b_vs, b_de, b_frame, b_locked;
    logic [CWB-1:0] b_x, b_y, b_ht, b_hr, b_vt, b_vr;

    display_timing_detector #(.H_POL(1'b0), .V_POL(1'b0), .CW(CWA)) dut_a (
        .i_pixclk(clk), .i_rst_n(rst_n[0]),
        .i_hs(hs_i[0]), .i_vs(vs_i[0]), .i_de(de_i[0]),
        .o_hs(a_hs), .o_vs(a_vs), .o_de(a_de), .o_x(a_x), .o_y(a_y), .o_frame(a_frame),
        .o_h_total(a_ht), .o_h_res(a_hr), .o_v_total(a_vt), .o_v_res(a_vr),
        .o_locked(a_locked)
    );

    display_timing_detector #(.H_POL(1'b1), .V_POL(1'b1), .CW(CWB)) dut_b (
        .i_pixclk(clk), .i_rst_n(rst_n[1]),
        .i_hs(hs_i[1]), .i_vs(vs_i[1]), .i_de(de_i[1]),
        .o_hs(b_hs), .o_vs(b_vs), .o_de(b_de), .o_x(b_x), .o_y(b_y), .o_frame(b_frame),
        .o_h_total(b_ht), .o_h_res(b_hr), .o_v_total(b_vt), .o_v_res(b_vr),
        .o_locked(b_locked)
    );

    bit o_hs_v[2], o_vs_v[2], o_de_v[2], o_fr_v[2], o_lk_v[2];
    int o_x_v[2], o_y_v[2], o_ht_v[2], o_hr_v[2], o_vt_v[2], o_vr_v[2];

    always_comb begin
        o_hs_v[0] = a_hs;  o_vs_v[0] = a_vs;  o_de_v[0] = a_de;
        o_fr_v[0] = a_frame; o_lk_v[0] = a_locked;
        o_x_v[0]  = 32'(a_x);  o_y_v[0]  = 32'(a_y);
        o_ht_v[0] = 32'(a_ht); o_hr_v[0] = 32'(a_hr);
        o_vt_v[0] = 32'(a_vt); o_vr_v[0] = 32'(a_vr);
        o_hs_v[1] = b_hs;  o_vs_v[1] = b_vs;  o_de_v[1] = b_de;
        o_fr_v[1] = b_frame; o_lk_v[1] = b_locked;
        o_x_v[1]  = 32'(b_x);  o_y_v[1]  = 32'(b_y);
        o_ht_v[1] = 32'(b_ht); o_hr_v[1] = 32'(b_hr);
        o_vt_v[1] = 32'(b_vt); o_vr_v[1] = 32'(b_vr);
    end

    geo_t geo[2];
    int   gx[2], gy[2], cur_len[2];
    bit   run[2], stretch_req[2];

    bit m1h[2], m1v[2], m1d[2], m2h[2], m2v[2], m2d[2];
    int m1x[2], m1y[2], m2x[2], m2y[2];

    int checks = 0;
    int failures = 0;

    function automatic int htot(input int i);
        return geo[i].hs + geo[i].hbp + geo[i].hact + geo[i].hfp;
    endfunction

    function automatic int vtot(input int i);
        return geo[i].vs + geo[i].vbp + geo[i].vact + geo[i].vfp;
    endfunction

    function automatic int xs(input int i);
        return geo[i].hs + geo[i].hbp;
    endfunction

    function automatic int ys(input int i);
        return geo[i].vs + geo[i].vbp;
    endfunction

    function automatic bit gen_de(input int i);
        return run[i] && gx[i] >= xs(i) && gx[i] < xs(i) + geo[i].hact &&
               gy[i] >= ys(i) && gy[i] < ys(i) + geo[i].vact;
    endfunction

    task automatic drive(input int i);
        if (run[i]) begin
            hs_i[i] = (gx[i] < geo[i].hs) ? geo[i].pol : !geo[i].pol;
            vs_i[i] = (gy[i] < geo[i].vs) ? geo[i].pol : !geo[i].pol;
        end else begin
            hs_i[i] = !geo[i].pol;
            vs_i[i] = !geo[i].pol;
        end
        de_i[i] = gen_de(i);
    endtask

    task automatic advance(input int i);
        if (run[i]) begin
            gx[i]++;
            if (gx[i] >= cur_len[i]) begin
                gx[i] = 0;
                gy[i]++;
                if (gy[i] >= vtot(i)) gy[i] = 0;
                cur_len[i] = htot(i) + (stretch_req[i] ? 1 : 0);
                stretch_req[i] = 1'b0;
            end
        end
    endtask

    task automatic start_stream(input int i);
        gx[i] = 0;
        gy[i] = 0;
        cur_len[i] = htot(i);
        run[i] = 1'b1;
        drive(i);
    endtask

    task automatic clear_model(input int i);
        m1h[i] = 0; m1v[i] = 0; m1d[i] = 0; m1x[i] = 0; m1y[i] = 0;
        m2h[i] = 0; m2v[i] = 0; m2d[i] = 0; m2x[i] = 0; m2y[i] = 0;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock: advance the pipeline model with what the DUT just sampled, compare, drive next inputs
    task automatic tick();
        bit ok;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rst_n[i]) begin
                m2h[i] = m1h[i]; m2v[i] = m1v[i]; m2d[i] = m1d[i];
                m2x[i] = m1x[i]; m2y[i] = m1y[i];
                m1h[i] = hs_i[i]; m1v[i] = vs_i[i]; m1d[i] = de_i[i];
                m1x[i] = gx[i] - xs(i); m1y[i] = gy[i] - ys(i);
            end
            ok = (o_hs_v[i] == m2h[i]) && (o_vs_v[i] == m2v[i]) && (o_de_v[i] == m2d[i]) &&
                 (o_fr_v[i] == (m2d[i] && m2x[i] == 0 && m2y[i] == 0)) &&
                 (!m2d[i] || (o_x_v[i] == m2x[i] && o_y_v[i] == m2y[i]));
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL pipe%0d t=%0t: got hs=%0d vs=%0d de=%0d x=%0d y=%0d frame=%0d expected hs=%0d vs=%0d de=%0d x=%0d y=%0d",
                         i, $time, o_hs_v[i], o_vs_v[i], o_de_v[i], o_x_v[i], o_y_v[i], o_fr_v[i],
                         m2h[i], m2v[i], m2d[i], m2x[i], m2y[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            advance(i);
            drive(i);
        end
    endtask

    task automatic wait_pos(input int i, input int y, input int x);
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (gy[i] == y && gx[i] == x) return;
        end
        chk("wait_pos_timeout", 1, 0);
    endtask

    task automatic chk_meas(input string nm, input int i, input int ht, input int hr,
                            input int vt, input int vr);
        chk({nm, "_h_total"}, o_ht_v[i], ht);
        chk({nm, "_h_res"},   o_hr_v[i], hr);
        chk({nm, "_v_total"}, o_vt_v[i], vt);
        chk({nm, "_v_res"},   o_vr_v[i], vr);
    endtask

    vec_t tbl[8];
    int   cur_frame;

    initial begin
        geo[0] = '{4, 6, 24, 6, 2, 3, 12, 3, 1'b0};
        geo[1] = '{5, 7, 32, 6, 2, 2, 10, 2, 1'b1};

        // frame k: checked 10 cycles after the (k+1)-th vsync leading edge since the stream started
        tbl[0] = '{0, 0, 1'b0, 1'b0, 0, 0, 0, 0};
        tbl[1] = '{0, 1, 1'b0, 1'b0, 0, 0, 0, 0};
        tbl[2] = '{1, 0, 1'b1, 1'b0, 40, 24, 20, 12};
        tbl[3] = '{1, 1, 1'b1, 1'b0, 50, 32, 16, 10};
        tbl[4] = '{2, 0, 1'b1, 1'b1, 40, 24, 20, 12};
        tbl[5] = '{2, 1, 1'b1, 1'b1, 50, 32, 16, 10};
        tbl[6] = '{3, 0, 1'b1, 1'b1, 40, 24, 20, 12};
        tbl[7] = '{3, 1, 1'b1, 1'b1, 50, 32, 16, 10};

        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0;
            run[i] = 1'b0;
            stretch_req[i] = 1'b0;
            gx[i] = 0;
            gy[i] = 0;
            cur_len[i] = htot(i);
            clear_model(i);
            drive(i);
        end
        repeat (3) tick();
        chk("reset_h_total_a", o_ht_v[0], 0);
        chk("reset_locked_b", o_lk_v[1], 0);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        repeat (3) tick();
        start_stream(0);
        start_stream(1);

        cur_frame = -1;
        for (int k = 0; k < 8; k++) begin
            while (cur_frame < tbl[k].frame) begin
                wait_pos(0, 0, 10);
                cur_frame++;
            end
            chk($sformatf("tbl%0d_locked", k), o_lk_v[tbl[k].inst], tbl[k].locked);
            if (tbl[k].chk_meas) begin
                chk_meas($sformatf("tbl%0d", k), tbl[k].inst,
                         tbl[k].ht, tbl[k].hr, tbl[k].vt, tbl[k].vr);
            end
        end

        // one line stretched by a cycle: lock drops at its closing hsync, returns two vsyncs later
        wait_pos(0, 5, 0);
        stretch_req[0] = 1'b1;
        wait_pos(0, 6, 38);
        chk("stretch_before_locked", o_lk_v[0], 1);
        wait_pos(0, 7, 5);
        chk("stretch_locked", o_lk_v[0], 0);
        chk("stretch_h_total", o_ht_v[0], 41);
        wait_pos(0, 8, 5);
        chk("stretch_next_h_total", o_ht_v[0], 40);
        chk("stretch_next_locked", o_lk_v[0], 0);
        wait_pos(0, 0, 10);
        chk("stretch_v1_locked", o_lk_v[0], 0);
        wait_pos(0, 0, 10);
        chk("stretch_v2_locked", o_lk_v[0], 1);

        // loss of sync long enough to saturate the 12-bit line counter
        wait_pos(0, 0, 20);
        run[0] = 1'b0;
        drive(0);
        repeat (5000) tick();
        chk("loss_locked", o_lk_v[0], 0);
        chk_meas("loss_hold", 0, 40, 24, 20, 12);
        start_stream(0);
        wait_pos(0, 0, 10);
        chk("restore_v1_locked", o_lk_v[0], 0);
        wait_pos(0, 0, 10);
        wait_pos(0, 0, 10);
        chk("restore_v3_locked", o_lk_v[0], 1);

        // asynchronous reset in the middle of a line
        wait_pos(0, 3, 15);
        #2;
        rst_n[0] = 1'b0;
        #1;
        chk("async_rst_any_nonzero",
            int'(a_hs | a_vs | a_de | a_frame | a_locked | (|a_x) | (|a_y) |
                 (|a_ht) | (|a_hr) | (|a_vt) | (|a_vr)), 0);
        chk("async_rst_h_total", o_ht_v[0], 0);
        clear_model(0);
        run[0] = 1'b0;
        drive(0);
        repeat (3) tick();
        rst_n[0] = 1'b1;
        repeat (3) tick();
        start_stream(0);
        wait_pos(0, 0, 10);
        chk("rerst_v1_locked", o_lk_v[0], 0);
        wait_pos(0, 0, 10);
        chk("rerst_v2_locked", o_lk_v[0], 0);
        wait_pos(0, 0, 10);
        chk("rerst_v3_locked", o_lk_v[0], 1);
        chk_meas("rerst", 0, 40, 24, 20, 12);

        chk("b_final_locked", o_lk_v[1], 1);
        chk("b_final_h_total", o_ht_v[1], 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
